// File: rtl/ir_cmd_filter_pkg.sv
// Shared types and helpers for the IR command filter: SIRC frame layout,
// field extraction and the qualifier state encoding.
package ir_pkg;

  localparam int SIRC_W = 12;
  localparam int CMD_W  = 7;
  localparam int ADDR_W = 5;
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRMING,
    HELD
  } ir_state_t;

  // Command field: low bits of the frame.
  function automatic logic [CMD_W-1:0] sirc_cmd(input logic [SIRC_W-1:0] f);
    return f[CMD_W-1:0];
  endfunction

  // Address field: high bits of the frame.
  function automatic logic [ADDR_W-1:0] sirc_addr(input logic [SIRC_W-1:0] f);
    return f[SIRC_W-1 -: ADDR_W];
  endfunction

endpackage

// File: rtl/ir_cmd_filter_if.sv
// Frame input from the IR receiver and qualified command outputs towards
// the LED / display consumers. The filter itself uses the slave modport.
interface ir_cmd_filter_if;
  import ir_pkg::*;

  logic [SIRC_W-1:0] in_data;
  logic              in_data_rdy;
  logic [SIRC_W-1:0] cmd_buf;
  logic              new_cmd;
  logic              is_repeat;
  logic              held;
  logic [HOLD_W-1:0] hold_cnt;

  modport master (
    output in_data, in_data_rdy,
    input  cmd_buf, new_cmd, is_repeat, held, hold_cnt
  );

  modport slave (
    input  in_data, in_data_rdy,
    output cmd_buf, new_cmd, is_repeat, held, hold_cnt
  );

endinterface

// File: rtl/ir_cmd_filter_gap_timer.sv
// Gap timer: counts idle cycles between frames while a press is being
// qualified or held. Expiry is a one-cycle pulse on the last count of the
// gap; a restart in that same cycle suppresses it.
module ir_gap_timer #(
  parameter int GAP_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic expired
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(GAP_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign expired = run & ~restart & (r_cnt == LAST);

  // Count up while running; any restart, stop or expiry returns to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_cnt <= '0;
    else if (restart | ~run | expired) r_cnt <= '0;
    else                               r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/ir_cmd_filter.sv
// IR command qualifier. A frame is an edge on in_data_rdy; a command is
// accepted after CONFIRM identical consecutive frames, then tracked while
// the remote keeps auto-repeating it. Optional auto-fire of held buttons is
// enabled by defining IR_AUTOREPEAT_EN.
import ir_pkg::*;

module ir_cmd_filter #(
  parameter int GAP_CYCLES   = 5_000_000,
  parameter int CONFIRM      = 2,
  parameter int REPEAT_DELAY = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  ir_cmd_filter_if.slave bus
);

  if (CONFIRM < 1 || CONFIRM > 4) begin : g_bad_confirm
    $fatal(1, "ir_cmd_filter: CONFIRM must be in 1..4");
  end
  // hold_cnt saturates at 255, so larger delays could never fire.
  if (REPEAT_DELAY < 0 || REPEAT_DELAY > 255) begin : g_bad_delay
    $fatal(1, "ir_cmd_filter: REPEAT_DELAY must be in 0..255");
  end

  localparam logic [2:0] CONFIRM_M = 3'(CONFIRM);
`ifdef IR_AUTOREPEAT_EN
  localparam logic [HOLD_W-1:0] RPT_M = HOLD_W'(REPEAT_DELAY);
`endif

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (v == {HOLD_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  ir_state_t         r_state, w_state_nx;
  logic              r_rdy_q;
  logic [SIRC_W-1:0] r_cand, w_cand_nx;
  logic [2:0]        r_match, w_match_nx;
  logic [SIRC_W-1:0] r_cmd, w_cmd_nx;
  logic              r_new, w_new_nx;
  logic              r_rpt, w_rpt_nx;
  logic [HOLD_W-1:0] r_hold, w_hold_nx;

  logic w_ev, w_same, w_run, w_expired, w_fresh;
  logic [2:0]        w_match_inc;
  logic [HOLD_W-1:0] w_hold_inc;

  assign w_ev        = bus.in_data_rdy & ~r_rdy_q;
  assign w_same      = (bus.in_data == r_cand);
  assign w_run       = (r_state != IDLE);
  assign w_match_inc = r_match + 3'd1;
  assign w_hold_inc  = sat_inc(r_hold);

  ir_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (w_ev),
    .run     (w_run),
    .expired (w_expired)
  );

  // Next-state and output decode; a new candidate frame is handled the same
  // way from IDLE, CONFIRMING (mismatch) and HELD (different code).
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_match_nx = r_match;
    w_cmd_nx   = r_cmd;
    w_new_nx   = 1'b0;
    w_rpt_nx   = 1'b0;
    w_hold_nx  = r_hold;
    w_fresh    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ev) w_fresh = 1'b1;
      end
      CONFIRMING: begin
        if (w_ev) begin
          if (w_same) begin
            w_match_nx = w_match_inc;
            if (w_match_inc == CONFIRM_M) begin
              w_cmd_nx   = r_cand;
              w_new_nx   = 1'b1;
              w_hold_nx  = '0;
              w_state_nx = HELD;
            end
          end else begin
            w_fresh = 1'b1;
          end
        end else if (w_expired) begin
          w_state_nx = IDLE;
        end
      end
      HELD: begin
        if (w_ev) begin
          if (w_same) begin
            w_hold_nx = w_hold_inc;
`ifdef IR_AUTOREPEAT_EN
            if (w_hold_inc >= RPT_M) begin
              w_new_nx = 1'b1;
              w_rpt_nx = 1'b1;
            end
`endif
          end else begin
            w_fresh = 1'b1;
          end
        end else if (w_expired) begin
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
    if (w_fresh) begin
      w_cand_nx  = bus.in_data;
      w_match_nx = 3'd1;
      if (CONFIRM == 1) begin
        w_cmd_nx   = bus.in_data;
        w_new_nx   = 1'b1;
        w_hold_nx  = '0;
        w_state_nx = HELD;
      end else begin
        w_state_nx = CONFIRMING;
      end
    end
  end

  // State and output registers; rdy_q resets high so a level already
  // present at reset release is not mistaken for a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rdy_q <= 1'b1;
      r_cand  <= '0;
      r_match <= '0;
      r_cmd   <= '0;
      r_new   <= 1'b0;
      r_rpt   <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_rdy_q <= bus.in_data_rdy;
      r_cand  <= w_cand_nx;
      r_match <= w_match_nx;
      r_cmd   <= w_cmd_nx;
      r_new   <= w_new_nx;
      r_rpt   <= w_rpt_nx;
      r_hold  <= w_hold_nx;
    end
  end

  assign bus.cmd_buf   = r_cmd;
  assign bus.new_cmd   = r_new;
  assign bus.is_repeat = r_rpt;
  assign bus.held      = (r_state == HELD);
  assign bus.hold_cnt  = r_hold;

endmodule

// File: doc/ir_cmd_filter.md
# ir_cmd_filter

Command qualifier between `ir_receiver` and the LED/display consumers. It samples the receiver's 12-bit SIRC frame output on each rising edge of `in_data_rdy` and requires `CONFIRM` identical consecutive frames before accepting a command. It then tracks button hold through the remote's auto-repeated frames, separated by a configurable gap timeout. Outputs are a one-cycle `new_cmd` strobe and a held `cmd_buf`, which drive `led_mgr` and `command_display` directly.

## Interface
- `GAP_CYCLES`, default 5_000_000: clock cycles without a frame after which a press is considered released (100 ms at 50 MHz).
- `CONFIRM`, default 2: identical consecutive frames needed to accept a command; legal range 1..4.
- `REPEAT_DELAY`, default 5: held frames before auto-fire starts; used only with `IR_AUTOREPEAT_EN`.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in 12: frame from `ir_receiver`, as {address[4:0], command[6:0]}.
- `in_data_rdy` in 1: receiver ready level; a rising edge marks one new frame.
- `cmd_buf` out 12: last accepted command, held until the next acceptance.
- `new_cmd` out 1: one-cycle strobe on acceptance.
- `is_repeat` out 1: valid with `new_cmd`; 1 means an auto-fire emission.
- `held` out 1: 1 while an accepted command is still being received.
- `hold_cnt` out 8: frames received since acceptance; saturates at 255.

## Operation
- `rdy_q` registers `in_data_rdy`. Frame event `ev = in_data_rdy & ~rdy_q`.
- Registers: `cand[11:0]`, `match_cnt[2:0]`, gap timer, state.
- **IDLE**
  - Timer is held at 0; `held` = 0.
  - On `ev`: `cand <= in_data`, `match_cnt <= 1`.
  - If `CONFIRM == 1`, emit and go to HELD; otherwise go to CONFIRMING.
- **CONFIRMING**
  - `ev` with `in_data == cand`: increment `match_cnt`. When it reaches `CONFIRM`, emit and go to HELD.
  - `ev` with different data: `cand <= in_data`, `match_cnt <= 1`, stay.
  - Timer expiry: go to IDLE.
- **HELD**
  - `held` = 1.
  - `ev` with same data: restart timer, `hold_cnt` +1 (saturating).
  - `ev` with different data: handled exactly like the IDLE `ev` rule, except `held` drops to 0 if the next state is CONFIRMING.
  - Timer expiry: go to IDLE; `held` = 0; `hold_cnt` keeps its value until the next emit.
- **Emit:** `cmd_buf <= cand` (or `in_data` on the `CONFIRM == 1` path), `new_cmd <= 1`, `is_repeat <= 0`, `hold_cnt <= 0`.
- **Gap timer**
  - Restarts at 0 on every `ev`.
  - Expiry is when the count equals `GAP_CYCLES-1` with no `ev` in that cycle.
  - `ev` in the expiry cycle wins: the frame counts as within the gap.

## Timing
- Reset values:
  - `cmd_buf` = 12'h000; `new_cmd`, `is_repeat`, `held` = 0; `hold_cnt` = 0.
  - State IDLE, timer 0.
  - `rdy_q` = 1, so a ready level already high at reset release generates no event.
- Latency: `new_cmd` and `cmd_buf` update on the clock edge after the cycle in which `ev` is true. `new_cmd` is exactly one cycle wide.
- At most one emit per `ev`; no emit without an `ev`.
- Reset assertion mid-operation clears everything immediately, including a `new_cmd` in progress.
- `CONFIRM` outside 1..4 is a fatal elaboration-time error.

## Configuration
- `IR_AUTOREPEAT_EN` defined:
  - In HELD, a same-code `ev` that brings `hold_cnt` to `REPEAT_DELAY` or above also emits with `is_repeat = 1`.
  - In this case `cmd_buf` is unchanged and `hold_cnt` is not cleared.
- Undefined: HELD never emits; `is_repeat` is constant 0; `REPEAT_DELAY` is ignored.

## Structure
- Package `ir_pkg` holds:
  - `SIRC_W = 12`, plus `CMD_W = 7` and `ADDR_W = 5` with field-extract helpers.
  - The state typedef {IDLE, CONFIRMING, HELD}.
- One sub-module, `ir_gap_timer`. Inputs: `clk`, `rst_n`, `restart`, `run`. Output: one-cycle `expired`. Parameter: `GAP_CYCLES`. Counter width is `$clog2(GAP_CYCLES)`.

## Test plan
All scenarios use `GAP_CYCLES = 1000`, `CONFIRM = 2`, `REPEAT_DELAY = 3`, with 200-cycle frame spacing.
1. Two 12'h095 frames → one `new_cmd` one cycle after the 2nd edge; `cmd_buf` = 12'h095; `held` = 1.
2. Frames 12'h095 then 12'h012 then 12'h012 → single `new_cmd` with `cmd_buf` = 12'h012; no emit for 12'h095.
3. Accept 12'h095, then 1000 idle cycles → `held` falls at expiry; an `ev` landing exactly in the expiry cycle keeps `held` = 1.
4. Eight held 12'h095 frames → `hold_cnt` = 6. With `IR_AUTOREPEAT_EN`: `new_cmd` with `is_repeat = 1` on the frames that reach `hold_cnt` 3 through 6. Without it: no further `new_cmd`.
5. `in_data_rdy` high across `rst_n` release → no event; reset asserted in CONFIRMING → all outputs at reset values, and the next two frames are needed again.
